arbitro_mux2x1: RTL and testbench
=================================

ARBITRO_MUX2X1 -- requirements
Module: arbitro_mux2x1

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles before preemption; legal range 1..255.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req_a  input  1  requester A (mux data input 0) wants the shared mux.
REQ-006 Port: req_b  input  1  requester B (mux data input 1) wants the shared mux.
REQ-007 Port: gnt_a  output  1  A owns the mux path.
REQ-008 Port: gnt_b  output  1  B owns the mux path.
REQ-009 Port: sel  output  1  drives the 2x1 mux select; 0 = A, 1 = B.
REQ-010 Port: busy  output  1  equals gnt_a OR gnt_b.
REQ-011 Port: prio  output  1  next-priority pointer; 0 = A wins a tie, 1 = B wins a tie.

Function
REQ-012 The FSM SHALL have four states: IDLE, OWN_A, OWN_B, GAP; all outputs SHALL be registered.
REQ-013 IDLE and GAP SHALL arbitrate using the requests sampled at the edge:
- req_a only -> OWN_A.
- req_b only -> OWN_B.
- both -> OWN_A if prio=0, else OWN_B.
- none -> IDLE.
REQ-014 Grant latency SHALL be exactly one cycle: a request sampled at edge N in IDLE yields gnt high after edge N.
REQ-015 In OWN_A: gnt_a=1, gnt_b=0, sel=0. In OWN_B: gnt_b=1, gnt_a=0, sel=1.
REQ-016 gnt_a and gnt_b SHALL never be high in the same cycle.
REQ-017 In IDLE and GAP, both grants SHALL be 0 and sel SHALL hold its last value.
REQ-018 Each grant issue SHALL set prio to the other requester: grant to A -> prio=1; grant to B -> prio=0.
REQ-019 An 8-bit hold counter SHALL clear to 0 on entry to OWN_x and increment each cycle in OWN_x.
REQ-020 OWN_x SHALL go to GAP when req_x is sampled low (voluntary release).
REQ-021 OWN_x SHALL go to GAP when the counter equals MAX_HOLD-1 and the other request is high (preemption).
REQ-022 If the counter equals MAX_HOLD-1 and the other request is low, the FSM SHALL stay in OWN_x with the counter cleared to 0.
REQ-023 If release and expiry coincide, the block SHALL treat it as a voluntary release; the result is GAP either way.
REQ-024 GAP SHALL last exactly one cycle, giving a dead cycle between owners so sel never switches while a grant is high.
REQ-025 With MAX_HOLD=1, an owner SHALL be preempted after every single grant cycle while the other requester is high.
REQ-026 A requester holding req continuously SHALL be granted within MAX_HOLD+2 cycles (starvation bound).

Reset
REQ-027 Reset assertion SHALL immediately, without a clock edge, force: state IDLE, gnt_a=0, gnt_b=0, sel=0, busy=0, prio=0, counter=0.
REQ-028 Reset asserted mid-grant SHALL drop the grant asynchronously.
REQ-029 After reset release, the first arbitration SHALL occur at the first rising edge with rst_n high.

Verification
REQ-030 Scenario, single requester: req_a=1 at edge 1 -> gnt_a=1 and sel=0 after edge 1; req_a=0 at edge 5 -> GAP for one cycle, then IDLE.
REQ-031 Scenario, tie after reset: req_a=req_b=1 -> A granted, prio=1; A holds 8 cycles, then GAP, then B granted with sel=1 and prio=0.
REQ-032 Scenario, no contention: MAX_HOLD=8, req_a held 20 cycles, req_b=0 -> gnt_a stays high all 20 cycles with no GAP.
REQ-033 Scenario, coincident release: A releases on the same edge its counter hits 7 while req_b=1 -> exactly one GAP cycle, then gnt_b=1.
REQ-034 Scenario, reset mid-grant: rst_n low in OWN_B between clock edges -> gnt_b=0, sel=0, prio=0 immediately; after release, req_b=1 gives gnt_b after one edge.
REQ-035 Scenario, randomized: random requests over 10,000 cycles -> no dual grant, sel matches the owner whenever busy=1, starvation bound REQ-026 holds.

Source files
------------

// File: rtl/arbitro_mux2x1.sv
// Two-requester arbiter that owns the select of a shared 2x1 mux.
// Round-robin tie break, bounded hold time, and a one-cycle dead gap between owners.
module arbitro_mux2x1 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy,
  output logic prio
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_gnt_a;
  logic       r_gnt_b;
  logic       r_sel;
  logic       r_busy;
  logic       r_prio;
  logic       w_gnt_a_nxt;
  logic       w_gnt_b_nxt;
  logic       w_sel_nxt;
  logic       w_busy_nxt;
  logic       w_prio_nxt;
  logic       w_expire;

  assign w_expire = (r_cnt == LP_LAST);

  // Next-state and next-output decode; outputs are computed one edge ahead and registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gnt_a_nxt = 1'b0;
    w_gnt_b_nxt = 1'b0;
    w_sel_nxt   = r_sel;
    w_prio_nxt  = r_prio;
    case (r_state)
      IDLE, GAP: begin
        w_cnt_nxt = 8'd0;
        if (req_a && (!req_b || !r_prio)) begin
          w_state_nxt = OWN_A;
          w_gnt_a_nxt = 1'b1;
          w_sel_nxt   = 1'b0;
          w_prio_nxt  = 1'b1;
        end else if (req_b) begin
          w_state_nxt = OWN_B;
          w_gnt_b_nxt = 1'b1;
          w_sel_nxt   = 1'b1;
          w_prio_nxt  = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN_A: begin
        // A release that coincides with expiry falls into the first branch.
        if (!req_a) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 8'd0;
        end else if (w_expire && req_b) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_gnt_a_nxt = 1'b1;
          w_cnt_nxt   = w_expire ? 8'd0 : (r_cnt + 8'd1);
        end
      end
      OWN_B: begin
        if (!req_b) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 8'd0;
        end else if (w_expire && req_a) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_gnt_b_nxt = 1'b1;
          w_cnt_nxt   = w_expire ? 8'd0 : (r_cnt + 8'd1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
    w_busy_nxt = w_gnt_a_nxt | w_gnt_b_nxt;
  end

  // State, hold counter and registered outputs; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt_a <= w_gnt_a_nxt;
      r_gnt_b <= w_gnt_b_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign prio  = r_prio;

endmodule

// File: tb/tb_arbitro_mux2x1.sv
// Bench for arbitro_mux2x1: directed vector table, corner sequences, and a
// randomized run against an owner/hold-count model for MAX_HOLD=8 and MAX_HOLD=1.
module tb_arbitro_mux2x1;

  localparam int MH8 = 8;
  localparam int MH1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic gnt_a, gnt_b, sel, busy, prio;
  logic gnt_a1, gnt_b1, sel1, busy1, prio1;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic       ra;
    logic       rb;
    logic [4:0] exp;  // {gnt_a, gnt_b, sel, busy, prio}
  } vec_t;

  typedef struct {
    int owner;  // -1 none, 0 A, 1 B
    int held;
    int last;
    int prio;
  } mst_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  arbitro_mux2x1 #(.MAX_HOLD(MH8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .busy(busy), .prio(prio)
  );

  arbitro_mux2x1 #(.MAX_HOLD(MH1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .busy(busy1), .prio(prio1)
  );

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {ga,gb,sel,busy,prio}=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s @%0t: got violation expected none (ga=%b gb=%b sel=%b busy=%b)",
               name, $time, gnt_a, gnt_b, sel, busy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic ra, input logic rb, input logic [4:0] exp);
    vec_t v;
    v.ra = ra;
    v.rb = rb;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic mst_t mreset();
    mst_t s;
    s.owner = -1;
    s.held = 0;
    s.last = 0;
    s.prio = 0;
    return s;
  endfunction

  // Model: an owner keeps the mux until it lets go or has used up its hold window
  // while the other side waits; without an owner, the requests pick one immediately.
  function automatic mst_t mstep(mst_t s, logic ra, logic rb, int mh);
    mst_t n;
    logic mine, other;
    int w;
    n = s;
    if (s.owner >= 0) begin
      mine  = (s.owner == 0) ? ra : rb;
      other = (s.owner == 0) ? rb : ra;
      n.held = s.held + 1;
      if (!mine) n.owner = -1;
      else if (n.held == mh && other) n.owner = -1;
      else if (n.held == mh) n.held = 0;
    end else begin
      w = -1;
      if (ra && rb) w = s.prio;
      else if (ra) w = 0;
      else if (rb) w = 1;
      if (w >= 0) begin
        n.owner = w;
        n.held = 0;
        n.last = w;
        n.prio = 1 - w;
      end
    end
    return n;
  endfunction

  function automatic logic [4:0] mexp(mst_t s);
    return {(s.owner == 0), (s.owner == 1), (s.last == 1), (s.owner >= 0), (s.prio == 1)};
  endfunction

  initial begin
    mst_t m8, m1;
    int wa8, wb8, wa1, wb1;
    logic sa, sb;

    // Tie after reset, then release/re-request patterns (MAX_HOLD = 8).
    for (int i = 0; i < 8; i++) addv(1'b1, 1'b1, 5'b10011);
    addv(1'b1, 1'b1, 5'b00001);
    for (int i = 0; i < 8; i++) addv(1'b1, 1'b1, 5'b01110);
    addv(1'b1, 1'b1, 5'b00100);
    addv(1'b1, 1'b1, 5'b10011);
    addv(1'b0, 1'b0, 5'b00001);
    addv(1'b0, 1'b0, 5'b00001);
    addv(1'b0, 1'b1, 5'b01110);
    addv(1'b0, 1'b1, 5'b01110);
    addv(1'b0, 1'b0, 5'b00100);
    addv(1'b1, 1'b0, 5'b10011);
    addv(1'b0, 1'b0, 5'b00001);
    addv(1'b0, 1'b0, 5'b00001);

    #2;
    chk("reset_state", {gnt_a, gnt_b, sel, busy, prio}, 5'b00000);
    chk("reset_state_mh1", {gnt_a1, gnt_b1, sel1, busy1, prio1}, 5'b00000);
    #10;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      tick();
      chk($sformatf("vec%0d", i), {gnt_a, gnt_b, sel, busy, prio}, vecs[i].exp);
    end

    // No contention: A holds well past MAX_HOLD with no gap.
    req_a = 1'b1;
    req_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("no_contention%0d", i), {gnt_a, gnt_b, sel, busy, prio}, 5'b10011);
    end
    req_a = 1'b0;
    tick();
    chk("release_gap", {gnt_a, gnt_b, sel, busy, prio}, 5'b00001);
    tick();
    chk("release_idle", {gnt_a, gnt_b, sel, busy, prio}, 5'b00001);

    // Coincident release and expiry with B waiting.
    req_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("coinc_own%0d", i), {gnt_a, gnt_b, sel, busy, prio}, 5'b10011);
    end
    req_b = 1'b1;
    tick();
    chk("coinc_last", {gnt_a, gnt_b, sel, busy, prio}, 5'b10011);
    req_a = 1'b0;
    tick();
    chk("coinc_gap", {gnt_a, gnt_b, sel, busy, prio}, 5'b00001);
    tick();
    chk("coinc_gnt_b", {gnt_a, gnt_b, sel, busy, prio}, 5'b01110);

    // Reset mid-grant between edges, then regrant after one edge.
    tick();
    chk("own_b_before_rst", {gnt_a, gnt_b, sel, busy, prio}, 5'b01110);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_drop", {gnt_a, gnt_b, sel, busy, prio}, 5'b00000);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt_b", {gnt_a, gnt_b, sel, busy, prio}, 5'b01110);

    // Randomized run against the model for both hold limits.
    req_a = 1'b0;
    req_b = 1'b0;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    m8 = mreset();
    m1 = mreset();
    wa8 = 0; wb8 = 0; wa1 = 0; wb1 = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) req_a = ~req_a;
      if ($urandom_range(0, 7) == 0) req_b = ~req_b;
      sa = req_a;
      sb = req_b;
      m8 = mstep(m8, sa, sb, MH8);
      m1 = mstep(m1, sa, sb, MH1);
      tick();
      chk("rand_mh8", {gnt_a, gnt_b, sel, busy, prio}, mexp(m8));
      chk("rand_mh1", {gnt_a1, gnt_b1, sel1, busy1, prio1}, mexp(m1));
      chk_bit("dual_grant", !(gnt_a && gnt_b) && !(gnt_a1 && gnt_b1));
      chk_bit("sel_owner", (!busy || (sel == gnt_b)) && (!busy1 || (sel1 == gnt_b1)));
      wa8 = (sa && !gnt_a)  ? wa8 + 1 : 0;
      wb8 = (sb && !gnt_b)  ? wb8 + 1 : 0;
      wa1 = (sa && !gnt_a1) ? wa1 + 1 : 0;
      wb1 = (sb && !gnt_b1) ? wb1 + 1 : 0;
      chk_bit("starvation", (wa8 <= MH8 + 2) && (wb8 <= MH8 + 2) &&
                            (wa1 <= MH1 + 2) && (wb1 <= MH1 + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
